// File: rtl/cp0_regs_pkg.sv
// Shared CP0 register addresses, exception codes and exception decode used by the
// CP0 register file and by the EX stage.
package cp0_regs_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;

  localparam logic [31:0] EXC_TIMER   = 32'h0000_0004;
  localparam logic [31:0] EXC_SYSCALL = 32'h0000_0100;
  localparam logic [31:0] EXC_ERET    = 32'h0000_0200;

  localparam logic [31:0] CAUSE_SW_MASK = 32'h0000_0300;
  localparam logic [4:0]  EXCCODE_SYS   = 5'd8;

  typedef enum logic [1:0] {
    EXC_NONE,
    EXC_ENTRY_TMR,
    EXC_ENTRY_SYS,
    EXC_RET
  } exc_kind_e;

  // Unrecognised codes collapse to EXC_NONE so they behave exactly like "no exception".
  function automatic exc_kind_e decode_exc(input logic [31:0] excptype);
    exc_kind_e kind;
    kind = EXC_NONE;
    if (excptype == EXC_TIMER)        kind = EXC_ENTRY_TMR;
    else if (excptype == EXC_SYSCALL) kind = EXC_ENTRY_SYS;
    else if (excptype == EXC_ERET)    kind = EXC_RET;
    return kind;
  endfunction

endpackage

// File: rtl/cp0_regs_timer.sv
// Count/Compare timer: free-running Count with software load, Compare register and
// the match flag that drives the timer interrupt in Cause.
module cp0_regs_timer
  import cp0_regs_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        match
);

  logic [31:0] count_d, count_q;
  logic [31:0] compare_d, compare_q;

  always_comb begin
    count_d   = count_we ? wdata : count_q + 32'd1;
    compare_d = compare_we ? wdata : compare_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q   <= '0;
      compare_q <= '0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
    end
  end

  // Compare==0 disarms the timer, so reset does not fire an interrupt at Count==0.
  assign match   = (compare_q != 32'd0) && (count_q == compare_q);
  assign count   = count_q;
  assign compare = compare_q;

endmodule

// File: rtl/cp0_regs.sv
// Coprocessor-0 register file: Status/Cause/EPC, software access, exception entry/eret
// updates and the timer interrupt level.
module cp0_regs
  import cp0_regs_pkg::*;
#(
  parameter logic [31:0] STATUS_RST = 32'h0000_0401,
  parameter int          TIMER_BIT  = 10,
  parameter logic [31:0] HANDLER_PC = 32'h0000_0040
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata,
  input  logic [31:0] excptype,
  input  logic [31:0] pc,
  output logic [31:0] cause,
  output logic [31:0] status,
  output logic [31:0] epc,
  output logic        timer_int,
  output logic [31:0] excpc
);

  logic [31:0] status_d, status_q;
  logic [31:0] cause_d, cause_q;
  logic [31:0] epc_d, epc_q;
  logic [31:0] count, compare;
  logic        match;
  exc_kind_e   exc_kind;
  logic        sw_we;

  assign exc_kind = decode_exc(excptype);
  // A resolved exception or eret owns the CP0 state this cycle; mtc0 is dropped.
  assign sw_we    = we && (exc_kind == EXC_NONE);

  cp0_regs_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (sw_we && (waddr == CP0_COUNT)),
    .compare_we (sw_we && (waddr == CP0_COMPARE)),
    .wdata      (wdata),
    .count      (count),
    .compare    (compare),
    .match      (match)
  );

  always_comb begin
    status_d = status_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    if (sw_we) begin
      case (waddr)
        CP0_STATUS: status_d = wdata;
        CP0_CAUSE:  cause_d  = (cause_q & ~CAUSE_SW_MASK) | (wdata & CAUSE_SW_MASK);
        CP0_EPC:    epc_d    = wdata;
        default:    ;
      endcase
    end
    case (exc_kind)
      EXC_ENTRY_TMR: begin
        epc_d        = pc;
        status_d[1]  = 1'b1;
        cause_d[6:2] = 5'd0;
      end
      EXC_ENTRY_SYS: begin
        epc_d        = pc;
        status_d[1]  = 1'b1;
        cause_d[6:2] = EXCCODE_SYS;
      end
      EXC_RET:  status_d[1] = 1'b0;
      default:  ;
    endcase
    // Rewriting Compare acknowledges the interrupt and beats a coincident match.
    if (sw_we && (waddr == CP0_COMPARE)) cause_d[TIMER_BIT] = 1'b0;
    else if (match)                      cause_d[TIMER_BIT] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_q <= STATUS_RST;
      cause_q  <= '0;
      epc_q    <= '0;
    end else begin
      status_q <= status_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (sw_we && (waddr == raddr)) begin
      rdata = wdata;
    end else begin
      case (raddr)
        CP0_COUNT:   rdata = count;
        CP0_COMPARE: rdata = compare;
        CP0_STATUS:  rdata = status_q;
        CP0_CAUSE:   rdata = cause_q;
        CP0_EPC:     rdata = epc_q;
        default:     rdata = '0;
      endcase
    end
  end

  always_comb begin
    excpc = '0;
    case (exc_kind)
      EXC_ENTRY_TMR, EXC_ENTRY_SYS: excpc = HANDLER_PC;
      EXC_RET:                      excpc = epc_q;
      default:                      excpc = '0;
    endcase
  end

  assign cause     = cause_q;
  assign status    = status_q;
  assign epc       = epc_q;
  assign timer_int = cause_q[TIMER_BIT];

endmodule

// File: tb/tb_cp0_regs.sv
// Directed bench for cp0_regs: reset, timer interrupt, exception entry/eret,
// write masking/forwarding, Count wrap and asynchronous reset.
module tb_cp0_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic [31:0] excptype;
  logic [31:0] pc;
  logic [31:0] cause, status, epc, excpc;
  logic        timer_int;

  int n_assert = 0;
  int n_fail   = 0;

  cp0_regs dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .raddr     (raddr),
    .rdata     (rdata),
    .excptype  (excptype),
    .pc        (pc),
    .cause     (cause),
    .status    (status),
    .epc       (epc),
    .timer_int (timer_int),
    .excpc     (excpc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    step();
    we = 1'b0;
  endtask

  initial begin
    rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr = 5'd9;
    excptype = '0; pc = '0;

    // 1: reset state, then five idle cycles
    #12;
    check("rst_status", status, 32'h0000_0401);
    check("rst_cause",  cause,  32'h0);
    check("rst_epc",    epc,    32'h0);
    check("rst_tint",   {31'b0, timer_int}, 32'h0);
    check("rst_count",  rdata,  32'h0);
    rst = 1'b1;
    repeat (5) step();
    check("idle_count", rdata, 32'd5);
    check("idle_status", status, 32'h0000_0401);

    // 2: timer interrupt set by match, cleared by Compare write
    mtc0(5'd11, 32'd20);                 // count now 6
    repeat (14) step();                  // count now 20
    check("pre_match_count", rdata, 32'd20);
    check("pre_match_tint", {31'b0, timer_int}, 32'h0);
    step();
    check("match_tint", {31'b0, timer_int}, 32'h1);
    check("match_cause", cause, 32'h0000_0400);
    step();
    check("hold_tint", {31'b0, timer_int}, 32'h1);
    mtc0(5'd11, 32'd40);                 // count now 23
    check("clr_tint", {31'b0, timer_int}, 32'h0);

    // 3: timer exception entry
    excptype = 32'h4; pc = 32'h0000_1234;
    #1;
    check("tmr_excpc", excpc, 32'h0000_0040);
    step();
    excptype = '0;
    check("tmr_epc", epc, 32'h0000_1234);
    check("tmr_status", status, 32'h0000_0403);
    check("tmr_cause", cause, 32'h0);

    // 4: syscall entry, then eret
    excptype = 32'h100; pc = 32'h80;
    #1;
    check("sys_excpc", excpc, 32'h0000_0040);
    step();
    check("sys_epc", epc, 32'h80);
    check("sys_cause", cause, 32'h0000_0020);
    excptype = 32'h200; raddr = 5'd14;
    #1;
    check("eret_rdata", rdata, 32'h80);
    check("eret_excpc", excpc, 32'h80);
    step();
    excptype = '0;
    #1;
    check("eret_status", status, 32'h0000_0401);
    check("eret_epc", epc, 32'h80);
    check("eret_cause", cause, 32'h0000_0020);
    check("none_excpc", excpc, 32'h0);

    // 5: Cause write mask and forwarding; write dropped under an exception
    we = 1'b1; waddr = 5'd13; wdata = 32'hFFFF_FFFF; raddr = 5'd13;
    #1;
    check("fwd_rdata", rdata, 32'hFFFF_FFFF);
    step();
    we = 1'b0;
    check("mask_cause", cause, 32'h0000_0320);
    we = 1'b1; waddr = 5'd13; wdata = 32'h0; excptype = 32'h4; pc = 32'h2000;
    #1;
    check("nofwd_rdata", rdata, 32'h0000_0320);
    step();
    we = 1'b0; excptype = '0;
    check("drop_cause", cause, 32'h0000_0300);
    check("drop_epc", epc, 32'h2000);
    check("drop_status", status, 32'h0000_0403);
    mtc0(5'd12, 32'h0000_0401);
    check("sw_status", status, 32'h0000_0401);
    raddr = 5'd5;
    #1;
    check("unmapped_rd", rdata, 32'h0);

    // clear beats a coincident match
    raddr = 5'd9;
    mtc0(5'd9, 32'h100);
    check("count_load", rdata, 32'h100);
    mtc0(5'd11, 32'h102);                // count 0x101
    step();                              // count 0x102 == compare
    check("coinc_count", rdata, 32'h102);
    mtc0(5'd11, 32'h200);
    check("coinc_tint", {31'b0, timer_int}, 32'h0);
    step();
    check("coinc_tint2", {31'b0, timer_int}, 32'h0);

    // 6: Count wrap, pending interrupt, asynchronous reset
    mtc0(5'd11, 32'd1);
    mtc0(5'd9, 32'hFFFF_FFFE);
    check("wrap_m2", rdata, 32'hFFFF_FFFE);
    step();
    check("wrap_m1", rdata, 32'hFFFF_FFFF);
    step();
    check("wrap_0", rdata, 32'h0);
    step();                              // count 1 == compare
    step();
    check("wrap_tint", {31'b0, timer_int}, 32'h1);
    check("wrap_cause", cause, 32'h0000_0700);
    #3 rst = 1'b0;
    #1;
    check("arst_status", status, 32'h0000_0401);
    check("arst_cause", cause, 32'h0);
    check("arst_epc", epc, 32'h0);
    check("arst_tint", {31'b0, timer_int}, 32'h0);
    check("arst_count", rdata, 32'h0);
    raddr = 5'd11;
    #1;
    check("arst_compare", rdata, 32'h0);
    rst = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
